gsim_seq_ctrl: RTL and testbench
================================

Name: gsim_seq_ctrl

Overview:
- Top-level sequencer for the Gauss-Seidel iteration machine.
- Counts and routes the 16-bit input stream into the A/b operand store.
- Runs a fixed number of sweeps on the iteration core: once for mode 0 (solve Ax=b), or once per unit-vector column for mode 1 (inverse).
- Serializes 32-bit results MSB-byte-first on data_o with a contiguous out_valid burst.

Parameters:
- N, 8, matrix dimension (columns in mode 1; result words in mode 0)
- A_WORDS, 32, 16-bit words of A per problem
- B_WORDS, 4, 16-bit words of b (mode 0 only)
- ITER_MAX, 16, sweeps per solve/column (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_en  in  1  data_i valid this cycle
- mode  in  1  0 = solve, 1 = inverse; sampled on first accepted word
- data_i  in  16  input word
- wr_en  out  1  operand store write strobe
- wr_addr  out  6  store address: 0..A_WORDS-1 for A, A_WORDS..A_WORDS+B_WORDS-1 for b
- wr_data  out  16  equals data_i, combinational
- core_start  out  1  one-cycle pulse that starts one sweep
- rhs_sel  out  1  0 = loaded b, 1 = unit vector e_col
- col_idx  out  3  current inverse column (0 in mode 0)
- core_done  in  1  one-cycle pulse: sweep finished
- rd_en  out  1  result buffer read strobe; 1-cycle read latency
- rd_addr  out  6  result word index
- rd_data  in  32  result word
- out_valid  out  1  data_o valid
- data_o  out  8  output byte

Behaviour:
- Reset (sync, any state): state=IDLE; all counters cleared; every output is 0. Reset mid-load, mid-solve or mid-output aborts immediately; no partial burst continues.
- States: IDLE, LOAD, START, WAIT, OUT, DONE.
- IDLE: on in_en=1, latch mode and write word 0 in the same cycle (wr_en=1, wr_addr=0). Go to LOAD, or to START if that was the final word.
- LOAD:
  - Each in_en=1 cycle writes at wr_addr=cnt, then cnt++.
  - in_en=0 cycles hold cnt; gaps are legal.
  - Total words: A_WORDS+B_WORDS in mode 0, A_WORDS in mode 1.
  - The cycle that writes the final word moves to START.
  - Words arriving in any other state are ignored (wr_en=0).
- START: core_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - core_done increments sweep_cnt.
  - If sweep_cnt reaches ITER_MAX:
    - mode 0, or col_idx=N-1: go to OUT.
    - otherwise: col_idx++, sweep_cnt=0, go to START.
  - Otherwise go to START.
  - core_done outside WAIT is ignored.
- rhs_sel=mode during START and WAIT; otherwise 0. col_idx holds its value through OUT and clears on reset.
- OUT:
  - Emits W words: W=N in mode 0 (32 bytes), W=N*N in mode 1 (256 bytes).
  - Entry cycle: rd_en=1, rd_addr=0.
  - Next cycle: rd_data is captured into a shift register.
  - out_valid rises the following cycle, i.e. final core_done at T gives the first out_valid at T+3.
  - Bytes per word are sent [31:24], [23:16], [15:8], [7:0].
  - The next word is read (rd_en=1, rd_addr=w+1) in the cycle that outputs byte [23:16]. It is captured at the end of the [7:0] cycle, so out_valid has no gaps.
  - out_valid stays high for exactly 4*W consecutive cycles. After the last byte go to DONE.
- DONE: out_valid=0, data_o=0; ignores in_en and core_done until reset.
- data_o=0 whenever out_valid=0.
- Counter widths: cnt 6b, sweep_cnt covers ITER_MAX, byte index 2b, word index 6b. rd_addr never exceeds W-1.

Test Plan:
- Mode 0, ITER_MAX=4, core model pulses core_done 3 cycles after each core_start; 36 contiguous words -> exactly 4 core_start pulses, rhs_sel=0; result words 0x11223344.. give 32 out_valid cycles starting T+3, first byte 0x11.
- Mode 1, ITER_MAX=2 -> 16 core_start pulses; col_idx steps 0..7, two pulses each; rhs_sel=1; 256 contiguous bytes; rd_addr 0..63 in order.
- Load with in_en gaps (word pairs separated by 3 idle cycles) -> wr_addr 0..35 with no skips; START only after the 36th write; mode changed mid-load has no effect.
- Spurious core_done during LOAD and a 37th in_en word after load -> ignored: no wr_en, sweep_cnt unchanged.
- Reset asserted in WAIT (col_idx=3) and again at byte 10 of OUT -> next cycle all outputs 0, state IDLE; a fresh load completes normally.
- DONE hold: after the burst, drive in_en for 10 cycles -> no wr_en, no out_valid until reset.

Source files
------------

// File: rtl/gsim_seq_ctrl_if.sv
// Handshake bundle between the Gauss-Seidel sequencer and its environment:
// operand load stream, operand store writes, iteration core control and result readout.
interface gsim_seq_ctrl_if;
   logic        in_en;
   logic        mode;
   logic [15:0] data_i;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic        core_start;
   logic        rhs_sel;
   logic [2:0]  col_idx;
   logic        core_done;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic [7:0]  data_o;

   modport master (
      input  in_en, mode, data_i, core_done, rd_data,
      output wr_en, wr_addr, wr_data, core_start, rhs_sel, col_idx,
             rd_en, rd_addr, out_valid, data_o
   );

   modport slave (
      output in_en, mode, data_i, core_done, rd_data,
      input  wr_en, wr_addr, wr_data, core_start, rhs_sel, col_idx,
             rd_en, rd_addr, out_valid, data_o
   );
endinterface

// File: rtl/gsim_seq_ctrl.sv
// Top-level sequencer of the Gauss-Seidel machine: loads A/b, drives the sweep
// schedule of the iteration core and streams 32-bit results out as bytes.
module gsim_seq_ctrl #(
   parameter int N        = 8,
   parameter int A_WORDS  = 32,
   parameter int B_WORDS  = 4,
   parameter int ITER_MAX = 16
) (
   input logic            clk,
   input logic            reset,
   gsim_seq_ctrl_if.master bus
);

   localparam int          SW      = $clog2(ITER_MAX + 1);
   localparam logic [5:0]  LAST_M0 = 6'(A_WORDS + B_WORDS - 1);
   localparam logic [5:0]  LAST_M1 = 6'(A_WORDS - 1);
   localparam logic [5:0]  WORD_M0 = 6'(N - 1);
   localparam logic [5:0]  WORD_M1 = 6'(N * N - 1);
   localparam logic [2:0]  COL_END = 3'(N - 1);
   localparam logic [SW-1:0] SWEEP_END = SW'(ITER_MAX - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      OUT,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [SW-1:0] sweep_q, sweep_d;
   logic [2:0]    col_q, col_d;
   logic          mode_q, mode_d;
   logic [1:0]    byte_q, byte_d;
   logic [5:0]    word_q, word_d;
   logic [31:0]   shift_q, shift_d;
   logic          core_start_q, core_start_d;
   logic          rhs_sel_q, rhs_sel_d;
   logic          rd_en_q, rd_en_d;
   logic [5:0]    rd_addr_q, rd_addr_d;
   logic          out_valid_q, out_valid_d;

   logic          accept;
   logic          mode_eff;
   logic [5:0]    load_last;
   logic [5:0]    last_word;

   // The first word decides the problem size, so IDLE looks at the live mode input.
   assign mode_eff  = (state_q == IDLE) ? bus.mode : mode_q;
   assign load_last = mode_eff ? LAST_M1 : LAST_M0;
   assign last_word = mode_q ? WORD_M1 : WORD_M0;
   assign accept    = bus.in_en & ((state_q == IDLE) | (state_q == LOAD));

   assign bus.wr_en      = accept & ~reset;
   assign bus.wr_addr    = (bus.wr_en && state_q == LOAD) ? cnt_q : 6'd0;
   assign bus.wr_data    = bus.data_i;
   assign bus.core_start = core_start_q;
   assign bus.rhs_sel    = rhs_sel_q;
   assign bus.col_idx    = col_q;
   assign bus.rd_en      = rd_en_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.data_o     = out_valid_q ? shift_q[31:24] : 8'd0;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sweep_d     = sweep_q;
      col_d       = col_q;
      mode_d      = mode_q;
      byte_d      = byte_q;
      word_d      = word_q;
      shift_d     = shift_q;
      rd_addr_d   = rd_addr_q;
      rd_en_d     = 1'b0;
      out_valid_d = out_valid_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_en) begin
               mode_d  = bus.mode;
               cnt_d   = 6'd1;
               state_d = (load_last == 6'd0) ? START : LOAD;
            end
         end
         LOAD: begin
            if (bus.in_en) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == load_last) begin
                  state_d = START;
               end
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.core_done) begin
               sweep_d = sweep_q + 1'b1;
               state_d = START;
               if (sweep_q == SWEEP_END) begin
                  if (!mode_q || col_q == COL_END) begin
                     state_d   = OUT;
                     rd_en_d   = 1'b1;
                     rd_addr_d = 6'd0;
                     word_d    = 6'd0;
                  end else begin
                     col_d   = col_q + 3'd1;
                     sweep_d = '0;
                  end
               end
            end
         end
         OUT: begin
            // Before the burst: the entry cycle issues the read, the next one captures it.
            if (!out_valid_q) begin
               if (!rd_en_q) begin
                  shift_d     = bus.rd_data;
                  out_valid_d = 1'b1;
                  byte_d      = 2'd0;
               end
            end else if (byte_q == 2'd3) begin
               if (word_q == last_word) begin
                  out_valid_d = 1'b0;
                  shift_d     = 32'd0;
                  state_d     = DONE;
               end else begin
                  shift_d = bus.rd_data;
                  word_d  = word_q + 6'd1;
                  byte_d  = 2'd0;
               end
            end else begin
               shift_d = {shift_q[23:0], 8'h00};
               byte_d  = byte_q + 2'd1;
               if (byte_q == 2'd0 && word_q != last_word) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = word_q + 6'd1;
               end
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      core_start_d = (state_d == START);
      rhs_sel_d    = ((state_d == START) || (state_d == WAIT)) ? mode_d : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sweep_q      <= '0;
         col_q        <= '0;
         mode_q       <= 1'b0;
         byte_q       <= '0;
         word_q       <= '0;
         shift_q      <= '0;
         core_start_q <= 1'b0;
         rhs_sel_q    <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sweep_q      <= sweep_d;
         col_q        <= col_d;
         mode_q       <= mode_d;
         byte_q       <= byte_d;
         word_q       <= word_d;
         shift_q      <= shift_d;
         core_start_q <= core_start_d;
         rhs_sel_q    <= rhs_sel_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         out_valid_q  <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// Directed bench for gsim_seq_ctrl: two instances (ITER_MAX=4 and ITER_MAX=2) share
// the load stream; each has its own core and result-buffer responder.
module tb_gsim_seq_ctrl;

   localparam int IT0 = 4;
   localparam int IT1 = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_en = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] data_i = 16'd0;
   logic        spur_done = 1'b0;
   logic        sel = 1'b0;
   logic        clr = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   gsim_seq_ctrl_if if0 ();
   gsim_seq_ctrl_if if1 ();

   gsim_seq_ctrl #(.N(8), .A_WORDS(32), .B_WORDS(4), .ITER_MAX(IT0)) dut0 (
      .clk(clk), .reset(reset), .bus(if0)
   );
   gsim_seq_ctrl #(.N(8), .A_WORDS(32), .B_WORDS(4), .ITER_MAX(IT1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] wordVal(input logic [5:0] k);
      logic [7:0] kk;
      kk = {2'b00, k};
      return {8'h11 + kk, 8'h22 + kk, 8'h33 + kk, 8'h44 + kk};
   endfunction

   function automatic logic [7:0] expByte(input int i);
      logic [31:0] w;
      w = wordVal(6'(i / 4));
      case (i % 4)
         0:       return w[31:24];
         1:       return w[23:16];
         2:       return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   // Environment: core answers 3 cycles after core_start, result buffer has 1-cycle latency.
   logic [2:0]  cd0 = 3'd0, cd1 = 3'd0;
   logic [31:0] rd0 = 32'd0, rd1 = 32'd0;
   always @(posedge clk) begin
      if (reset) begin
         cd0 <= 3'd0; cd1 <= 3'd0; rd0 <= 32'd0; rd1 <= 32'd0;
      end else begin
         cd0 <= {cd0[1:0], if0.core_start};
         cd1 <= {cd1[1:0], if1.core_start};
         if (if0.rd_en) rd0 <= wordVal(if0.rd_addr);
         if (if1.rd_en) rd1 <= wordVal(if1.rd_addr);
      end
   end

   assign if0.in_en = in_en;   assign if1.in_en = in_en;
   assign if0.mode = mode;     assign if1.mode = mode;
   assign if0.data_i = data_i; assign if1.data_i = data_i;
   assign if0.core_done = cd0[2] | spur_done;
   assign if1.core_done = cd1[2] | spur_done;
   assign if0.rd_data = rd0;
   assign if1.rd_data = rd1;

   logic        m_wr_en, m_core_start, m_rhs_sel, m_rd_en, m_out_valid, m_core_done;
   logic [5:0]  m_wr_addr, m_rd_addr;
   logic [2:0]  m_col_idx;
   logic [7:0]  m_data_o;
   logic [15:0] m_wr_data;
   int          iter_sel;
   assign m_wr_en      = sel ? if1.wr_en      : if0.wr_en;
   assign m_wr_addr    = sel ? if1.wr_addr    : if0.wr_addr;
   assign m_wr_data    = sel ? if1.wr_data    : if0.wr_data;
   assign m_core_start = sel ? if1.core_start : if0.core_start;
   assign m_rhs_sel    = sel ? if1.rhs_sel    : if0.rhs_sel;
   assign m_col_idx    = sel ? if1.col_idx    : if0.col_idx;
   assign m_core_done  = sel ? if1.core_done  : if0.core_done;
   assign m_rd_en      = sel ? if1.rd_en      : if0.rd_en;
   assign m_rd_addr    = sel ? if1.rd_addr    : if0.rd_addr;
   assign m_out_valid  = sel ? if1.out_valid  : if0.out_valid;
   assign m_data_o     = sel ? if1.data_o     : if0.data_o;
   assign iter_sel     = sel ? IT1 : IT0;

   // Per-cycle statistics of the selected instance, sampled on the falling edge.
   int   wr_cnt = 0, wr_addr_err = 0, wr_at_start = -1, starts = 0, col_err = 0, rhs1_cnt = 0;
   int   rd_cnt = 0, rd_addr_err = 0, byte_cnt = 0, byte_err = 0, zero_err = 0;
   int   last_done = 0, first_ov = 0, last_ov = 0;
   logic [7:0] first_byte = 8'd0;
   logic burst_end = 1'b0;

   always @(negedge clk) begin
      if (clr) begin
         wr_cnt <= 0; wr_addr_err <= 0; wr_at_start <= -1; starts <= 0; col_err <= 0;
         rhs1_cnt <= 0; rd_cnt <= 0; rd_addr_err <= 0; byte_cnt <= 0; byte_err <= 0;
         zero_err <= 0; last_done <= 0; first_ov <= 0; last_ov <= 0;
         first_byte <= 8'd0; burst_end <= 1'b0;
      end else if (!reset) begin
         if (m_wr_en) begin
            if (m_wr_addr !== 6'(wr_cnt)) wr_addr_err <= wr_addr_err + 1;
            wr_cnt <= wr_cnt + 1;
         end
         if (m_core_start) begin
            if (starts == 0) wr_at_start <= wr_cnt;
            if (m_col_idx !== 3'(starts / iter_sel)) col_err <= col_err + 1;
            if (m_rhs_sel) rhs1_cnt <= rhs1_cnt + 1;
            starts <= starts + 1;
         end
         if (m_core_done) last_done <= cyc;
         if (m_rd_en) begin
            if (m_rd_addr !== 6'(rd_cnt)) rd_addr_err <= rd_addr_err + 1;
            rd_cnt <= rd_cnt + 1;
         end
         if (m_out_valid) begin
            if (byte_cnt == 0) begin
               first_ov   <= cyc;
               first_byte <= m_data_o;
            end
            if (m_data_o !== expByte(byte_cnt)) byte_err <= byte_err + 1;
            byte_cnt <= byte_cnt + 1;
            last_ov  <= cyc;
         end else begin
            if (m_data_o !== 8'd0) zero_err <= zero_err + 1;
            if (byte_cnt != 0) burst_end <= 1'b1;
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic md, input logic [15:0] d);
      in_en  = en;
      mode   = md;
      data_i = d;
      cycle();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearStats();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
   endtask

   task automatic doReset();
      in_en = 1'b0;
      reset = 1'b1;
      clr   = 1'b1;
      cycle();
      cycle();
      clr   = 1'b0;
      reset = 1'b0;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput(tag, 32'({m_wr_en, m_core_start, m_rhs_sel, m_col_idx, m_rd_en,
                            m_rd_addr, m_out_valid, m_data_o, m_wr_addr}), 32'd0);
   endtask

   task automatic loadWords(input logic md, input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, md, 16'hA000 + 16'(i));
      in_en = 1'b0;
   endtask

   task automatic waitBurst(input string tag, input int budget);
      int n;
      n = 0;
      while (!burst_end && n < budget) begin
         cycle();
         n++;
      end
      checkOutput(tag, 32'(burst_end), 32'd1);
   endtask

   task automatic checkBurst(input string tag, input int nbytes, input int nwords);
      checkOutput({tag, "_bytes"}, 32'(byte_cnt), 32'(nbytes));
      checkOutput({tag, "_contig"}, 32'(last_ov - first_ov + 1), 32'(nbytes));
      checkOutput({tag, "_data"}, 32'(byte_err), 32'd0);
      checkOutput({tag, "_first"}, 32'(first_byte), 32'h11);
      checkOutput({tag, "_rdcnt"}, 32'(rd_cnt), 32'(nwords));
      checkOutput({tag, "_rdaddr"}, 32'(rd_addr_err), 32'd0);
      checkOutput({tag, "_idlezero"}, 32'(zero_err), 32'd0);
   endtask

   initial begin
      int n;
      logic found;

      $display("[TB] start");
      doReset();
      sel = 1'b0;
      checkIdle("reset_dut0");
      sel = 1'b1;
      checkIdle("reset_dut1");

      // Mode 0 solve on the ITER_MAX=4 instance.
      sel = 1'b0;
      clearStats();
      loadWords(1'b0, 36);
      waitBurst("m0_burst_end", 400);
      checkOutput("m0_wr_cnt", 32'(wr_cnt), 32'd36);
      checkOutput("m0_wr_addr", 32'(wr_addr_err), 32'd0);
      checkOutput("m0_start_after_load", 32'(wr_at_start), 32'd36);
      checkOutput("m0_starts", 32'(starts), 32'd4);
      checkOutput("m0_rhs_sel", 32'(rhs1_cnt), 32'd0);
      checkOutput("m0_col", 32'(col_err), 32'd0);
      checkOutput("m0_latency", 32'(first_ov - last_done), 32'd3);
      checkBurst("m0", 32, 8);

      // DONE ignores further words.
      clearStats();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 16'h1234);
      in_en = 1'b0;
      checkOutput("done_no_wr", 32'(wr_cnt), 32'd0);
      checkOutput("done_no_ov", 32'(byte_cnt), 32'd0);
      checkOutput("done_no_start", 32'(starts), 32'd0);

      // Mode 1 inverse on the ITER_MAX=2 instance.
      sel = 1'b1;
      doReset();
      loadWords(1'b1, 32);
      waitBurst("m1_burst_end", 1000);
      checkOutput("m1_wr_cnt", 32'(wr_cnt), 32'd32);
      checkOutput("m1_start_after_load", 32'(wr_at_start), 32'd32);
      checkOutput("m1_starts", 32'(starts), 32'd16);
      checkOutput("m1_col_steps", 32'(col_err), 32'd0);
      checkOutput("m1_rhs_sel", 32'(rhs1_cnt), 32'd16);
      checkOutput("m1_col_hold", 32'(if1.col_idx), 32'd7);
      checkOutput("m1_latency", 32'(first_ov - last_done), 32'd3);
      checkBurst("m1", 256, 64);

      // Gapped load, mode flipped mid-load, spurious core_done, extra 37th word.
      sel = 1'b0;
      doReset();
      for (int i = 0; i < 36; i++) begin
         applyStimulus(1'b1, (i >= 10), 16'hA000 + 16'(i));
         if (i == 3) begin
            in_en  = 1'b0;
            data_i = 16'h5A5A;
            #1;
            checkOutput("gap_wr_data", 32'(m_wr_data), 32'h5A5A);
            checkOutput("gap_wr_en_low", 32'(m_wr_en), 32'd0);
         end
         if (i % 2 == 1 && i != 35) begin
            for (int g = 0; g < 3; g++) begin
               spur_done = (i == 5 && g == 1);
               applyStimulus(1'b0, 1'b1, 16'hBEEF);
            end
            spur_done = 1'b0;
         end
      end
      applyStimulus(1'b1, 1'b0, 16'hFFFF);
      in_en = 1'b0;
      checkOutput("gap_wr_cnt", 32'(wr_cnt), 32'd36);
      checkOutput("gap_wr_addr", 32'(wr_addr_err), 32'd0);
      checkOutput("gap_start_after_load", 32'(wr_at_start), 32'd36);
      waitBurst("gap_burst_end", 400);
      checkOutput("gap_starts", 32'(starts), 32'd4);
      checkOutput("gap_rhs_sel", 32'(rhs1_cnt), 32'd0);
      checkOutput("gap_bytes", 32'(byte_cnt), 32'd32);
      checkOutput("gap_data", 32'(byte_err), 32'd0);

      // Reset while waiting on the core in column 3.
      sel = 1'b1;
      doReset();
      loadWords(1'b1, 32);
      n = 0;
      found = 1'b0;
      while (!found && n < 600) begin
         if (m_core_start && m_col_idx == 3'd3) found = 1'b1;
         else begin
            cycle();
            n++;
         end
      end
      checkOutput("wait_col3_reached", 32'(found), 32'd1);
      cycle();
      reset = 1'b1;
      cycle();
      checkIdle("reset_in_wait");
      reset = 1'b0;

      // Reset during the output burst, then a clean run.
      sel = 1'b0;
      clearStats();
      loadWords(1'b0, 36);
      n = 0;
      while (byte_cnt < 10 && n < 400) begin
         cycle();
         n++;
      end
      checkOutput("out_byte10_reached", 32'(byte_cnt >= 10), 32'd1);
      reset = 1'b1;
      cycle();
      checkIdle("reset_in_out");
      reset = 1'b0;
      clearStats();
      for (int i = 0; i < 20; i++) cycle();
      checkOutput("abort_no_bytes", 32'(byte_cnt), 32'd0);
      checkOutput("abort_no_start", 32'(starts), 32'd0);
      clearStats();
      loadWords(1'b0, 36);
      waitBurst("fresh_burst_end", 400);
      checkOutput("fresh_starts", 32'(starts), 32'd4);
      checkBurst("fresh", 32, 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
